// File: rtl/fft_mux_pkg.sv
// Shared sizing helpers for the FFT read mux and write-side demux.
// Contents: radix limits and functions that split a select index into stages
// and locate each stage's vector inside a flat word chain.
package fft_mux_pkg;

  localparam int unsigned MAX_RADIX_LOG2 = 6;

  // Number of stages needed to resolve sel_w select bits, r bits per stage.
  function automatic int unsigned stage_count(input int unsigned sel_w, input int unsigned r);
    return (sel_w + r - 1) / r;
  endfunction

  // Select bits consumed by stage k; the last stage takes whatever remains.
  function automatic int unsigned stage_bits(input int unsigned k, input int unsigned sel_w,
                                             input int unsigned r);
    if (k == stage_count(sel_w, r) - 1) return sel_w - k * r;
    return r;
  endfunction

  // Word offset of stage k's input vector in the chain of all stage vectors.
  // Every stage except the last reduces by exactly 2**r, so stage i's input
  // holds n >> (i*r) words.
  function automatic int unsigned word_offset(input int unsigned n, input int unsigned r,
                                              input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < k; i++) off += n >> (i * r);
    return off;
  endfunction

endpackage

// File: rtl/fft_mux_stage.sv
// One registered reduction stage of the FFT read mux: N_IN words in,
// N_IN/2**R words out, selecting within each group of 2**R words using
// sel_i[SEL_LO +: R]. The full select and valid travel alongside the data.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           advance; 0 holds every register
//   valid_i/o      request qualifier in / registered
//   sel_i/o        full request index in / registered
//   data_i         flat N_IN*DATA_WIDTH input vector (word j at [j*DATA_WIDTH +: DATA_WIDTH])
//   data_o         flat registered N_OUT*DATA_WIDTH output vector
module fft_mux_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_IN       = 2048,
  parameter int unsigned R          = 4,
  parameter int unsigned SEL_W      = 11,
  parameter int unsigned SEL_LO     = 0,
  localparam int unsigned N_OUT     = N_IN >> R
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        valid_i,
  input  logic [SEL_W-1:0]            sel_i,
  input  logic [N_IN*DATA_WIDTH-1:0]  data_i,
  output logic                        valid_o,
  output logic [SEL_W-1:0]            sel_o,
  output logic [N_OUT*DATA_WIDTH-1:0] data_o
);

  localparam int unsigned RADIX = 1 << R;

  logic [R-1:0]                  idx;
  logic [N_OUT*DATA_WIDTH-1:0]   data_d, data_q;
  logic                          valid_q;
  logic [SEL_W-1:0]              sel_q;

  assign idx = sel_i[SEL_LO +: R];

  always_comb begin
    data_d = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      data_d[j*DATA_WIDTH +: DATA_WIDTH] = data_i[(j*RADIX + 32'(idx))*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The full select is carried rather than only the unconsumed bits, so the
  // same register doubles as the residual select and the echoed index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else if (en_i) begin
      data_q  <= data_d;
      valid_q <= valid_i;
      sel_q   <= sel_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sel_o   = sel_q;

endmodule

// File: rtl/fft_mux_pipe.sv
// Pipelined N_POINTS:1 read mux for the FFT core. Resolves RADIX_LOG2 select
// bits per registered stage, LSB first; latency is NUM_STAGES enabled cycles,
// throughput one request per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset (wins over en)
//   en         pipeline advance; 0 freezes every stage and ignores inputs
//   valid_i    sel/data_i carry a request this cycle
//   sel        element index to read
//   data_i     sample array [N_POINTS]
//   valid_o    data_o/sel_o carry a completed request
//   sel_o      index of the request on data_o
//   data_o     selected sample
module fft_mux_pipe
  import fft_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_POINTS   = 2048,
  parameter int unsigned RADIX_LOG2 = 4,
  localparam int unsigned SEL_W     = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid_i,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_WIDTH-1:0] data_i [N_POINTS],
  output logic                  valid_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (N_POINTS < 2 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_points
    $error("fft_mux_pipe: N_POINTS must be a power of two >= 2");
  end
  if (RADIX_LOG2 < 1 || RADIX_LOG2 > MAX_RADIX_LOG2) begin : g_bad_radix
    $error("fft_mux_pipe: RADIX_LOG2 out of range 1..6");
  end

  localparam int unsigned NUM_STAGES  = stage_count(SEL_W, RADIX_LOG2);
  localparam int unsigned CHAIN_WORDS = word_offset(N_POINTS, RADIX_LOG2, NUM_STAGES) + 1;

  // All stage vectors live back to back in one flat chain: data_i first,
  // then each stage's registered output, ending with the single final word.
  logic [CHAIN_WORDS*DATA_WIDTH-1:0] chain;
  logic [SEL_W-1:0]                  sel_c   [NUM_STAGES+1];
  logic                              valid_c [NUM_STAGES+1];

  for (genvar w = 0; w < N_POINTS; w++) begin : g_in
    assign chain[w*DATA_WIDTH +: DATA_WIDTH] = data_i[w];
  end

  assign sel_c[0]   = sel;
  assign valid_c[0] = valid_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int unsigned N_IN    = N_POINTS >> (k * RADIX_LOG2);
    localparam int unsigned RK      = stage_bits(k, SEL_W, RADIX_LOG2);
    localparam int unsigned N_OUT   = N_IN >> RK;
    localparam int unsigned OFF_IN  = word_offset(N_POINTS, RADIX_LOG2, k);
    localparam int unsigned OFF_OUT = word_offset(N_POINTS, RADIX_LOG2, k + 1);

    fft_mux_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_IN       (N_IN),
      .R          (RK),
      .SEL_W      (SEL_W),
      .SEL_LO     (k * RADIX_LOG2)
    ) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en),
      .valid_i (valid_c[k]),
      .sel_i   (sel_c[k]),
      .data_i  (chain[OFF_IN*DATA_WIDTH +: N_IN*DATA_WIDTH]),
      .valid_o (valid_c[k+1]),
      .sel_o   (sel_c[k+1]),
      .data_o  (chain[OFF_OUT*DATA_WIDTH +: N_OUT*DATA_WIDTH])
    );
  end

  assign data_o  = chain[(CHAIN_WORDS-1)*DATA_WIDTH +: DATA_WIDTH];
  assign valid_o = valid_c[NUM_STAGES];
  assign sel_o   = sel_c[NUM_STAGES];

endmodule

// File: tb/tb_fft_mux_pipe.sv
// Directed bench for fft_mux_pipe: default 2048-point instance plus small
// 8-point (radix 4/2 split) and 2-point instances.
module tb_fft_mux_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic        en, valid_i, valid_o;
  logic [10:0] sel, sel_o;
  logic [15:0] data_i [2048];
  logic [15:0] data_o;

  // 8-point instance
  logic        en8, valid8_i, valid8_o;
  logic [2:0]  sel8, sel8_o;
  logic [15:0] data8_i [8];
  logic [15:0] data8_o;

  // 2-point instance
  logic        en2, valid2_i, valid2_o;
  logic [0:0]  sel2, sel2_o;
  logic [15:0] data2_i [2];
  logic [15:0] data2_o;

  int checks = 0;
  int failures = 0;

  fft_mux_pipe #(.DATA_WIDTH(16), .N_POINTS(2048), .RADIX_LOG2(4)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .sel(sel), .data_i(data_i),
    .valid_o(valid_o), .sel_o(sel_o), .data_o(data_o)
  );

  fft_mux_pipe #(.DATA_WIDTH(16), .N_POINTS(8), .RADIX_LOG2(2)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .valid_i(valid8_i), .sel(sel8), .data_i(data8_i),
    .valid_o(valid8_o), .sel_o(sel8_o), .data_o(data8_o)
  );

  fft_mux_pipe #(.DATA_WIDTH(16), .N_POINTS(2), .RADIX_LOG2(4)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .valid_i(valid2_i), .sel(sel2), .data_i(data2_i),
    .valid_o(valid2_o), .sel_o(sel2_o), .data_o(data2_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] big(input logic v, input logic [10:0] s, input logic [15:0] d);
    return {4'h0, v, s, d};
  endfunction

  function automatic logic [31:0] big_obs();
    return {4'h0, valid_o, sel_o, data_o};
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; valid_i = 1'b0; sel = '0;
    en8 = 1'b0; valid8_i = 1'b0; sel8 = '0;
    en2 = 1'b0; valid2_i = 1'b0; sel2 = '0;
    for (int k = 0; k < 2048; k++) data_i[k] = 16'(k);
    for (int k = 0; k < 8; k++) data8_i[k] = 16'(k + 16'h10);
    for (int k = 0; k < 2; k++) data2_i[k] = 16'(k + 16'h20);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_big", big_obs(), big(1'b0, 11'h0, 16'h0));
    chk("rst_n8", {12'h0, valid8_o, sel8_o, data8_o}, 32'h0);
    chk("rst_n2", {14'h0, valid2_o, sel2_o, data2_o}, 32'h0);

    // 1: single read, latency 3
    rst = 1'b0; en = 1'b1; valid_i = 1'b1; sel = 11'h5A3;
    @(negedge clk); valid_i = 1'b0; sel = '0;
    @(negedge clk); chk("t1_early", {31'h0, valid_o}, 32'h0);
    @(negedge clk); chk("t1_out", big_obs(), big(1'b1, 11'h5A3, 16'h05A3));
    @(negedge clk); chk("t1_after", {31'h0, valid_o}, 32'h0);

    // 2: back-to-back streaming
    for (int i = 0; i <= 2050; i++) begin
      @(negedge clk);
      if (i >= 3) chk("t2_stream", big_obs(), big(1'b1, 11'(i - 3), 16'(i - 3)));
      if (i < 2048) begin valid_i = 1'b1; sel = 11'(i); end
      else valid_i = 1'b0;
    end
    chk("t2_last", {16'h0, data_o}, 32'h07FF);

    // 3: stall after 11 issued; valid_i during stall is dropped
    @(negedge clk); valid_i = 1'b1; sel = 11'd10;
    @(negedge clk); sel = 11'd11;
    @(negedge clk); chk("t3_pre", {31'h0, valid_o}, 32'h0);
    en = 1'b0; sel = 11'd99;
    @(negedge clk); chk("t3_stall1", {31'h0, valid_o}, 32'h0);
    @(negedge clk); chk("t3_stall2", {31'h0, valid_o}, 32'h0);
    en = 1'b1; sel = 11'd12;
    @(negedge clk); chk("t3_o10", big_obs(), big(1'b1, 11'd10, 16'd10));
    sel = 11'd13;
    @(negedge clk); chk("t3_o11", big_obs(), big(1'b1, 11'd11, 16'd11));
    valid_i = 1'b0;
    @(negedge clk); chk("t3_o12", big_obs(), big(1'b1, 11'd12, 16'd12));
    @(negedge clk); chk("t3_o13", big_obs(), big(1'b1, 11'd13, 16'd13));
    en = 1'b0;
    @(negedge clk); chk("t3_hold1", big_obs(), big(1'b1, 11'd13, 16'd13));
    @(negedge clk); chk("t3_hold2", big_obs(), big(1'b1, 11'd13, 16'd13));
    en = 1'b1;
    @(negedge clk); chk("t3_bubble", {31'h0, valid_o}, 32'h0);

    // 4: data_i sampled only in the issue cycle
    data_i[7] = 16'hBEEF; valid_i = 1'b1; sel = 11'd7;
    @(negedge clk); data_i[7] = 16'h0; valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("t4_hold", big_obs(), big(1'b1, 11'd7, 16'hBEEF));
    data_i[7] = 16'd7;

    // 5: reset mid-flight discards in-flight requests
    @(negedge clk); valid_i = 1'b1; sel = 11'd1;
    @(negedge clk); sel = 11'd2;
    @(negedge clk); sel = 11'd3; rst = 1'b1;
    @(negedge clk); chk("t5_reset", big_obs(), big(1'b0, 11'h0, 16'h0));
    rst = 1'b0; valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t5_none", {31'h0, valid_o}, 32'h0);
    end

    // 6: odd split (8 points, 2+1 bits) and the 2-point single stage
    en8 = 1'b1; valid8_i = 1'b1; sel8 = 3'd5;
    en2 = 1'b1; valid2_i = 1'b1; sel2 = 1'b1;
    @(negedge clk);
    chk("t6_n2_out", {14'h0, valid2_o, sel2_o, data2_o}, {14'h0, 1'b1, 1'b1, 16'h0021});
    chk("t6_n8_early", {31'h0, valid8_o}, 32'h0);
    valid8_i = 1'b0; valid2_i = 1'b0;
    @(negedge clk);
    chk("t6_n8_out", {12'h0, valid8_o, sel8_o, data8_o}, {12'h0, 1'b1, 3'd5, 16'h0015});
    chk("t6_n2_after", {31'h0, valid2_o}, 32'h0);
    @(negedge clk);
    chk("t6_n8_after", {31'h0, valid8_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
